// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writers after issue and resolves
// each source operand of the instruction in ID to either the register file, a
// bypass from one of the post-issue slots, or a stall when the value is not ready.
module hazard_scoreboard #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int DEPTH  = 3,
  parameter int LATW   = 2,
  parameter int FWD_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rs1,
  input  logic [AW-1:0]         iss_rs2,
  input  logic                  iss_use1,
  input  logic                  iss_use2,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  iss_we,
  input  logic [LATW-1:0]       iss_lat,
  input  logic [XLEN-1:0]       rf_rd1,
  input  logic [XLEN-1:0]       rf_rd2,
  input  logic [DEPTH*XLEN-1:0] fwd_data,
  input  logic                  flush,
  input  logic [DEPTH-1:0]      flush_mask,
  output logic [XLEN-1:0]       op_a,
  output logic [XLEN-1:0]       op_b,
  output logic [3:0]            fwd_sel_a,
  output logic [3:0]            fwd_sel_b,
  output logic                  stall,
  output logic [31:0]           stall_cnt
);

  // Slot k holds the writer that issued k+1 cycles ago (slot 0 = EX).
  logic [DEPTH-1:0] slot_v;
  logic [AW-1:0]    slot_rd  [DEPTH];
  logic [LATW-1:0]  slot_lat [DEPTH];

  // Both sources are resolved by the same loop, indexed 0 = A, 1 = B.
  logic [AW-1:0]   src_rs  [2];
  logic [1:0]      src_use;
  logic [XLEN-1:0] src_rf  [2];
  logic [XLEN-1:0] src_op  [2];
  logic [3:0]      src_sel [2];
  logic [1:0]      src_haz;

  logic            ins_v;
  logic [LATW-1:0] ins_lat;

  assign src_rs[0] = iss_rs1;
  assign src_rs[1] = iss_rs2;
  assign src_use   = {iss_use2, iss_use1};
  assign src_rf[0] = rf_rd1;
  assign src_rf[1] = rf_rd2;

  assign op_a      = src_op[0];
  assign op_b      = src_op[1];
  assign fwd_sel_a = src_sel[0];
  assign fwd_sel_b = src_sel[1];

  // A flushed issue never stalls, so a kill always lets the front end move on.
  assign stall   = iss_valid & ~flush & (|src_haz);
  assign ins_v   = iss_valid & iss_we & (iss_rd != '0) & ~stall & ~flush;
  assign ins_lat = (iss_lat == '0) ? LATW'(1) : iss_lat;

  // Scan slots youngest-first; the first match decides bypass, stall or nothing.
  always_comb begin
    logic found;
    for (int s = 0; s < 2; s++) begin
      src_op[s]  = src_rf[s];
      src_sel[s] = '0;
      src_haz[s] = 1'b0;
      found      = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && src_use[s] && (src_rs[s] != '0) &&
            slot_v[k] && (slot_rd[k] == src_rs[s])) begin
          found = 1'b1;
          if (FWD_EN == 0) begin
            src_haz[s] = 1'b1;
          end else if (k >= int'(slot_lat[k]) - 1) begin
            src_op[s]  = fwd_data[k*XLEN +: XLEN];
            src_sel[s] = 4'(k + 1);
          end else begin
            src_haz[s] = 1'b1;
          end
        end
      end
    end
  end

  // Advance the slot pipeline every cycle; masked entries lose valid as they move.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        slot_rd[k]  <= '0;
        slot_lat[k] <= '0;
      end
    end else begin
      slot_v      <= {slot_v[DEPTH-2:0] & ~flush_mask[DEPTH-2:0], ins_v};
      slot_rd[0]  <= iss_rd;
      slot_lat[0] <= ins_lat;
      for (int k = 1; k < DEPTH; k++) begin
        slot_rd[k]  <= slot_rd[k-1];
        slot_lat[k] <= slot_lat[k-1];
      end
    end
  end

  // Count stalled cycles, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: drives scripted issue sequences into a forwarding
// instance and a stall-only instance, queueing the expected outputs for each
// cycle and comparing them when the cycle's outputs are sampled.
module tb_hazard_scoreboard;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int LATW  = 2;

  localparam logic [31:0] RF1 = 32'hAAAA_0001;
  localparam logic [31:0] RF2 = 32'hBBBB_0002;
  localparam logic [31:0] FD0 = 32'h0000_1234;
  localparam logic [31:0] FD1 = 32'h5678_0001;
  localparam logic [31:0] FD2 = 32'h9ABC_0002;

  // Output selectors: *1 = forwarding instance, *0 = stall-only instance.
  localparam int SIG_STALL1 = 0;
  localparam int SIG_SELA1  = 1;
  localparam int SIG_OPA1   = 2;
  localparam int SIG_SELB1  = 3;
  localparam int SIG_OPB1   = 4;
  localparam int SIG_CNT1   = 5;
  localparam int SIG_STALL0 = 6;
  localparam int SIG_SELA0  = 7;
  localparam int SIG_OPA0   = 8;
  localparam int SIG_CNT0   = 9;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  iss_valid;
  logic [AW-1:0]         iss_rs1, iss_rs2, iss_rd;
  logic                  iss_use1, iss_use2, iss_we;
  logic [LATW-1:0]       iss_lat;
  logic [XLEN-1:0]       rf_rd1, rf_rd2;
  logic [DEPTH*XLEN-1:0] fwd_data;
  logic                  flush;
  logic [DEPTH-1:0]      flush_mask;

  logic [XLEN-1:0] op_a1, op_b1, op_a0, op_b0;
  logic [3:0]      sel_a1, sel_b1, sel_a0, sel_b0;
  logic            stall1, stall0;
  logic [31:0]     cnt1, cnt0;

  hazard_scoreboard #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .LATW(LATW), .FWD_EN(1)) u_fwd (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_use1(iss_use1), .iss_use2(iss_use2), .iss_rd(iss_rd), .iss_we(iss_we),
    .iss_lat(iss_lat), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .fwd_data(fwd_data),
    .flush(flush), .flush_mask(flush_mask), .op_a(op_a1), .op_b(op_b1),
    .fwd_sel_a(sel_a1), .fwd_sel_b(sel_b1), .stall(stall1), .stall_cnt(cnt1)
  );

  hazard_scoreboard #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .LATW(LATW), .FWD_EN(0)) u_nofwd (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_use1(iss_use1), .iss_use2(iss_use2), .iss_rd(iss_rd), .iss_we(iss_we),
    .iss_lat(iss_lat), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .fwd_data(fwd_data),
    .flush(flush), .flush_mask(flush_mask), .op_a(op_a0), .op_b(op_b0),
    .fwd_sel_a(sel_a0), .fwd_sel_b(sel_b0), .stall(stall0), .stall_cnt(cnt0)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(int sig);
    case (sig)
      SIG_STALL1: return {31'b0, stall1};
      SIG_SELA1:  return {28'b0, sel_a1};
      SIG_OPA1:   return op_a1;
      SIG_SELB1:  return {28'b0, sel_b1};
      SIG_OPB1:   return op_b1;
      SIG_CNT1:   return cnt1;
      SIG_STALL0: return {31'b0, stall0};
      SIG_SELA0:  return {28'b0, sel_a0};
      SIG_OPA0:   return op_a0;
      SIG_CNT0:   return cnt0;
      default:    return 32'hDEAD_DEAD;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expectOut(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drainScoreboard();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput(e.tag, observe(e.sig), e.val);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [AW-1:0] rs1, input logic u1,
                               input logic [AW-1:0] rs2, input logic u2,
                               input logic [AW-1:0] rd, input logic we,
                               input logic [LATW-1:0] lat, input logic fl,
                               input logic [DEPTH-1:0] mask);
    iss_valid  = v;
    iss_rs1    = rs1;
    iss_use1   = u1;
    iss_rs2    = rs2;
    iss_use2   = u2;
    iss_rd     = rd;
    iss_we     = we;
    iss_lat    = lat;
    flush      = fl;
    flush_mask = mask;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
  endtask

  // Compare this cycle's queued expectations just before the next edge, then advance.
  task automatic endCycle();
    #3;
    drainScoreboard();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      endCycle();
    end
  endtask

  initial begin
    rst      = 1'b0;
    rf_rd1   = RF1;
    rf_rd2   = RF2;
    fwd_data = {FD2, FD1, FD0};

    // Reset state: a reader sees the register file and nothing stalls.
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 2'd1, 1'b0, 3'b000);
    #3;
    expectOut("rst_stall", SIG_STALL1, 32'd0);
    expectOut("rst_sel_a", SIG_SELA1, 32'd0);
    expectOut("rst_op_a",  SIG_OPA1, RF1);
    expectOut("rst_op_b",  SIG_OPB1, RF2);
    expectOut("rst_cnt",   SIG_CNT1, 32'd0);
    drainScoreboard();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ALU back-to-back: add x5 then read x5 bypasses from slot 0.
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd1, 1'b0, 3'b000);
    expectOut("alu_issue_stall", SIG_STALL1, 32'd0);
    endCycle();
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 2'd1, 1'b0, 3'b000);
    expectOut("alu_stall", SIG_STALL1, 32'd0);
    expectOut("alu_sel_a", SIG_SELA1, 32'd1);
    expectOut("alu_op_a",  SIG_OPA1, FD0);
    expectOut("alu_sel_b", SIG_SELB1, 32'd0);
    expectOut("alu_op_b",  SIG_OPB1, RF2);
    endCycle();
    idleCycles(3);

    // Youngest wins: x3 in slot 2 and slot 0, reader picks slot 0.
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd1, 1'b0, 3'b000);
    endCycle();
    idleCycles(1);
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd1, 1'b0, 3'b000);
    endCycle();
    applyStimulus(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 2'd1, 1'b0, 3'b000);
    expectOut("young_stall", SIG_STALL1, 32'd0);
    expectOut("young_sel_a", SIG_SELA1, 32'd1);
    expectOut("young_op_a",  SIG_OPA1, FD0);
    expectOut("young_sel_b", SIG_SELB1, 32'd1);
    endCycle();
    idleCycles(3);

    // Load-use: one stall cycle, then bypass from slot 1; x0 source stays on RF.
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd2, 1'b0, 3'b000);
    endCycle();
    applyStimulus(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 2'd1, 1'b0, 3'b000);
    expectOut("ld_stall_1", SIG_STALL1, 32'd1);
    expectOut("ld_cnt_0",   SIG_CNT1, 32'd0);
    endCycle();
    expectOut("ld_stall_2", SIG_STALL1, 32'd0);
    expectOut("ld_sel_a",   SIG_SELA1, 32'd2);
    expectOut("ld_op_a",    SIG_OPA1, FD1);
    expectOut("ld_sel_b",   SIG_SELB1, 32'd0);
    expectOut("ld_op_b",    SIG_OPB1, RF2);
    expectOut("ld_cnt_1",   SIG_CNT1, 32'd1);
    endCycle();
    idle();
    expectOut("ld_cnt_hold", SIG_CNT1, 32'd1);
    endCycle();
    idleCycles(3);

    // Flush mask on slot 0: same cycle still stalls, next cycle reads RF.
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 2'd2, 1'b0, 3'b000);
    endCycle();
    applyStimulus(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0, 3'b001);
    expectOut("fm_same_stall", SIG_STALL1, 32'd1);
    endCycle();
    applyStimulus(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0, 3'b000);
    expectOut("fm_next_stall", SIG_STALL1, 32'd0);
    expectOut("fm_sel_a",      SIG_SELA1, 32'd0);
    expectOut("fm_op_a",       SIG_OPA1, RF1);
    expectOut("fm_cnt",        SIG_CNT1, 32'd2);
    endCycle();
    idleCycles(3);

    // Issue flush: no stall and the killed writer never enters slot 0.
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 2'd2, 1'b0, 3'b000);
    endCycle();
    applyStimulus(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 2'd1, 1'b1, 3'b000);
    expectOut("fl_stall", SIG_STALL1, 32'd0);
    endCycle();
    applyStimulus(1'b1, 5'd11, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 2'd1, 1'b0, 3'b000);
    expectOut("fl_next_stall", SIG_STALL1, 32'd0);
    expectOut("fl_sel_a",      SIG_SELA1, 32'd0);
    expectOut("fl_op_a",       SIG_OPA1, RF1);
    expectOut("fl_sel_b",      SIG_SELB1, 32'd2);
    expectOut("fl_op_b",       SIG_OPB1, FD1);
    expectOut("fl_cnt",        SIG_CNT1, 32'd2);
    endCycle();
    idleCycles(3);

    // x0 write followed by x0 reads: no stall, no bypass.
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'd2, 1'b0, 3'b000);
    endCycle();
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 2'd1, 1'b0, 3'b000);
    expectOut("x0_stall", SIG_STALL1, 32'd0);
    expectOut("x0_sel_a", SIG_SELA1, 32'd0);
    expectOut("x0_op_a",  SIG_OPA1, RF1);
    expectOut("x0_op_b",  SIG_OPB1, RF2);
    endCycle();
    idleCycles(3);

    // Async reset in the middle of a stall, away from any clock edge.
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 2'd3, 1'b0, 3'b000);
    endCycle();
    applyStimulus(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0, 3'b000);
    #2;
    expectOut("ar_pre_stall", SIG_STALL1, 32'd1);
    drainScoreboard();
    rst = 1'b0;
    #1;
    expectOut("ar_stall", SIG_STALL1, 32'd0);
    expectOut("ar_cnt",   SIG_CNT1, 32'd0);
    expectOut("ar_sel_a", SIG_SELA1, 32'd0);
    expectOut("ar_op_a",  SIG_OPA1, RF1);
    drainScoreboard();
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    expectOut("ar_post_stall", SIG_STALL1, 32'd0);
    expectOut("ar_post_op_a",  SIG_OPA1, RF1);
    expectOut("ar_post_cnt",   SIG_CNT1, 32'd0);
    endCycle();

    // Stall-only mode: ALU x9 then reader stalls three cycles, then RF.
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd1, 1'b0, 3'b000);
    expectOut("nf_issue_stall", SIG_STALL0, 32'd0);
    endCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0, 3'b000);
      expectOut($sformatf("nf_stall_%0d", i), SIG_STALL0, 32'd1);
      expectOut($sformatf("nf_sel_%0d", i),   SIG_SELA0, 32'd0);
      expectOut($sformatf("nf_cnt_%0d", i),   SIG_CNT0, 32'(i));
      endCycle();
    end
    applyStimulus(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0, 3'b000);
    expectOut("nf_done_stall", SIG_STALL0, 32'd0);
    expectOut("nf_done_sel",   SIG_SELA0, 32'd0);
    expectOut("nf_done_op",    SIG_OPA0, RF1);
    expectOut("nf_done_cnt",   SIG_CNT0, 32'd3);
    endCycle();

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
